// File: rtl/yuv420_subsampler.sv
// 4:4:4 raster stream to 4:2:0: luma passes through, chroma is 2x2 box averaged
// using a half-width line buffer of horizontal pair sums.
module yuv420_subsampler #(
    parameter int SENSOR_X_SIZE = 720,
    parameter int SENSOR_Y_SIZE = 720,
    parameter int DW            = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DW-1:0]                    yuv_in [2:0],
    input  logic                             yuv_in_valid,
    output logic                             yuv_in_hold,
    input  logic [$clog2(SENSOR_X_SIZE)-1:0] x_size_m1,
    input  logic [$clog2(SENSOR_Y_SIZE)-1:0] y_size_m1,
    output logic [DW-1:0]                    yuvrgb_out [2:0],
    output logic [2:0]                       yuvrgb_out_valid,
    input  logic                             yuvrgb_out_hold,
    output logic                             eof_out,
    output logic [$clog2(SENSOR_X_SIZE)-1:0] yuvrgb_out_pixel_count,
    output logic [$clog2(SENSOR_Y_SIZE)-1:0] yuvrgb_out_line_count
);

    localparam int XW = $clog2(SENSOR_X_SIZE);
    localparam int YW = $clog2(SENSOR_Y_SIZE);
    localparam int AW = XW - 1;
    localparam int LD = (SENSOR_X_SIZE + 1) / 2;
    localparam int SW = DW + 1;

    logic [XW-1:0]   px, px_nxt;
    logic [YW-1:0]   ln, ln_nxt;
    logic [DW-1:0]   held_u, held_v;
    logic            v_pending, v_eof;
    logic [DW-1:0]   v_val;
    logic [2*SW-1:0] lbuf [LD];
    logic [2*SW-1:0] lb_rd;
    logic [AW-1:0]   lb_raddr, lb_waddr;
    logic            accept, even_px, last_px, last_ln;
    logic            pair_done, emit, lb_we, frame_end;
    logic [SW-1:0]   hs_u, hs_v, a_u, a_v;
    logic [DW-1:0]   avg_u, avg_v;

    function automatic logic [DW-1:0] chroma_avg(
        input logic [SW-1:0] a,
        input logic [SW-1:0] b
    );
        logic [DW+2:0] s;
        s = {2'b00, a} + {2'b00, b} + (DW+3)'(2);
        s = s >> 2;
        return (s > (DW+3)'({DW{1'b1}})) ? {DW{1'b1}} : s[DW-1:0];
    endfunction

    assign yuv_in_hold = yuvrgb_out_hold | v_pending;
    assign accept      = yuv_in_valid & ~yuv_in_hold;
    assign even_px     = ~px[0];
    assign last_px     = (px == x_size_m1);
    assign last_ln     = (ln == y_size_m1);
    assign frame_end   = last_px & last_ln;
    assign pair_done   = ~even_px | last_px;
    assign emit        = pair_done & (ln[0] | last_ln);
    assign lb_we       = accept & pair_done & ~ln[0];

    assign px_nxt = last_px ? '0 : px + XW'(1);
    assign ln_nxt = last_px ? (last_ln ? '0 : ln + YW'(1)) : ln;

    assign hs_u = even_px ? {yuv_in[1], 1'b0}
                          : {1'b0, held_u} + {1'b0, yuv_in[1]};
    assign hs_v = even_px ? {yuv_in[2], 1'b0}
                          : {1'b0, held_v} + {1'b0, yuv_in[2]};

    // Odd lines add the buffered pair above; an odd last line doubles itself.
    assign a_u   = ln[0] ? lb_rd[2*SW-1:SW] : hs_u;
    assign a_v   = ln[0] ? lb_rd[SW-1:0]    : hs_v;
    assign avg_u = chroma_avg(a_u, hs_u);
    assign avg_v = chroma_avg(a_v, hs_v);

    // Read tracks the next pixel's pair; same-cycle writes are forwarded.
    assign lb_waddr = px[XW-1:1];
    assign lb_raddr = accept ? px_nxt[XW-1:1] : px[XW-1:1];

    always_ff @(posedge clk) begin
        if (lb_we)
            lbuf[lb_waddr] <= {hs_u, hs_v};
        if (lb_we && lb_waddr == lb_raddr)
            lb_rd <= {hs_u, hs_v};
        else
            lb_rd <= lbuf[lb_raddr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px                     <= '0;
            ln                     <= '0;
            held_u                 <= '0;
            held_v                 <= '0;
            v_pending              <= 1'b0;
            v_val                  <= '0;
            v_eof                  <= 1'b0;
            yuvrgb_out[0]          <= '0;
            yuvrgb_out[1]          <= '0;
            yuvrgb_out[2]          <= '0;
            yuvrgb_out_valid       <= 3'b000;
            eof_out                <= 1'b0;
            yuvrgb_out_pixel_count <= '0;
            yuvrgb_out_line_count  <= '0;
        end else begin
            if (accept) begin
                px <= px_nxt;
                ln <= ln_nxt;
                if (even_px) begin
                    held_u <= yuv_in[1];
                    held_v <= yuv_in[2];
                end
            end
            if (!yuvrgb_out_hold) begin
                if (v_pending) begin
                    yuvrgb_out_valid <= 3'b100;
                    yuvrgb_out[2]    <= v_val;
                    eof_out          <= v_eof;
                    v_pending        <= 1'b0;
                end else if (accept) begin
                    yuvrgb_out_valid       <= emit ? 3'b011 : 3'b001;
                    yuvrgb_out[0]          <= yuv_in[0];
                    if (emit)
                        yuvrgb_out[1]      <= avg_u;
                    yuvrgb_out_pixel_count <= px;
                    yuvrgb_out_line_count  <= ln;
                    eof_out                <= frame_end & ~emit;
                    v_pending              <= emit;
                    v_val                  <= avg_v;
                    v_eof                  <= frame_end;
                end else begin
                    yuvrgb_out_valid <= 3'b000;
                    eof_out          <= 1'b0;
                end
            end
        end
    end

endmodule
